// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider: NUM_CH independent divided outputs with
// glitch-free divisor changes at period boundaries, clean per-channel stop and global sync.
module clock_div_multi #(
  parameter  int NUM_CH      = 4,
  parameter  int SIZE        = 8,
  parameter  int DEFAULT_DIV = 6,
  localparam int CHW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              in,
  input  logic              resetb,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_valid,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [SIZE-1:0]   cfg_div,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] running
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // First count value of the high phase: high for the last div>>1 cycles.
  function automatic logic [SIZE-1:0] high_start(input logic [SIZE-1:0] d);
    return d - (d >> 1);
  endfunction

  logic [NUM_CH-1:0] w_cfg_hit;
  logic [NUM_CH-1:0] w_pending;

  // Out-of-range channel numbers match no channel, so they are accepted and dropped.
  always_comb begin
    cfg_ready = 1'b1;
    w_cfg_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CHW'(i)) begin
        cfg_ready    = !w_pending[i];
        w_cfg_hit[i] = cfg_valid && !w_pending[i];
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t          r_state, w_state_nxt;
    logic [SIZE-1:0] r_cnt, w_cnt_nxt;
    logic [SIZE-1:0] r_div, w_div_nxt;
    logic [SIZE-1:0] r_pend_div;
    logic            r_pending, w_pending_nxt;
    logic            r_out, w_out_nxt;
    logic            r_tick;
    logic            r_running;
    logic            w_active;
    logic            w_bound;
    logic            w_apply;

    always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_div_nxt     = r_div;
      w_pending_nxt = r_pending;
      w_active      = (r_state != ST_IDLE);
      w_bound       = w_active && (r_cnt == r_div - SIZE'(1));
      // Pending value lands when idle, at a boundary, or on sync; a write accepted
      // this same cycle cannot coexist with a pending one, so it simply stays pending.
      w_apply       = r_pending && (!w_active || w_bound || sync);
      if (w_apply) begin
        w_div_nxt     = r_pend_div;
        w_pending_nxt = 1'b0;
      end
      if (w_cfg_hit[i]) w_pending_nxt = 1'b1;

      unique case (r_state)
        ST_IDLE: begin
          w_cnt_nxt = '0;
          if (en[i] && (w_div_nxt > SIZE'(1))) w_state_nxt = ST_RUN;
        end
        default: begin
          if (sync || w_bound) begin
            w_cnt_nxt = '0;
            if (!en[i] || (w_div_nxt < SIZE'(2)) || (sync && (r_state == ST_DRAIN)))
              w_state_nxt = ST_IDLE;
            else
              w_state_nxt = ST_RUN;
          end else begin
            w_cnt_nxt   = r_cnt + SIZE'(1);
            w_state_nxt = en[i] ? ST_RUN : ST_DRAIN;
          end
        end
      endcase

      w_out_nxt = (w_state_nxt != ST_IDLE) && (w_cnt_nxt >= high_start(w_div_nxt));
    end

    always_ff @(posedge in or negedge resetb) begin
      if (!resetb) begin
        r_state    <= ST_IDLE;
        r_cnt      <= '0;
        r_div      <= SIZE'(DEFAULT_DIV);
        r_pend_div <= '0;
        r_pending  <= 1'b0;
        r_out      <= 1'b0;
        r_tick     <= 1'b0;
        r_running  <= 1'b0;
      end else begin
        r_state    <= w_state_nxt;
        r_cnt      <= w_cnt_nxt;
        r_div      <= w_div_nxt;
        r_pending  <= w_pending_nxt;
        r_out      <= w_out_nxt;
        r_tick     <= w_out_nxt && !r_out;
        r_running  <= (w_state_nxt != ST_IDLE);
        if (w_cfg_hit[i]) r_pend_div <= cfg_div;
      end
    end

    assign w_pending[i] = r_pending;
    assign out[i]       = r_out;
    assign tick[i]      = r_tick;
    assign running[i]   = r_running;
  end

endmodule
